// File: rtl/gpio_bank_controller_if.sv
// ----------------------------------------------------------------------------
// gpio_bank_controller_if
//
// Command/writeback channel between the IO manager and an IO module.
//   IOOut_* : command from the manager (REQ/ACK handshake, opcode+value, tag)
//   IOIn_*  : response back to the manager (REQ/ACK handshake, data, tag)
//
// Modports:
//   master : the IO manager side (drives commands, accepts responses)
//   slave  : the IO module side (accepts commands, drives responses)
// ----------------------------------------------------------------------------
interface gpio_bank_controller_if;
  logic        IOOut_REQ;
  logic        IOOut_ACK;
  logic        IOOut_ResponseRequested;
  logic [3:0]  IOOut_DestReg;
  logic [19:0] IOOut_Data;

  logic        IOIn_REQ;
  logic        IOIn_ACK;
  logic        IOIn_RegResponseFlag;
  logic        IOIn_MemResponseFlag;
  logic [3:0]  IOIn_DestReg;
  logic [15:0] IOIn_Data;

  modport master (
    output IOOut_REQ, IOOut_ResponseRequested, IOOut_DestReg, IOOut_Data,
    output IOIn_ACK,
    input  IOOut_ACK,
    input  IOIn_REQ, IOIn_RegResponseFlag, IOIn_MemResponseFlag,
    input  IOIn_DestReg, IOIn_Data
  );

  modport slave (
    input  IOOut_REQ, IOOut_ResponseRequested, IOOut_DestReg, IOOut_Data,
    input  IOIn_ACK,
    output IOOut_ACK,
    output IOIn_REQ, IOIn_RegResponseFlag, IOIn_MemResponseFlag,
    output IOIn_DestReg, IOIn_Data
  );
endinterface

// File: rtl/gpio_bank_controller.sv
// ----------------------------------------------------------------------------
// gpio_bank_controller
//
// GPIOWIDTH-wide GPIO bank on the IO manager command/writeback channel.
// Atomic WRITE/SET/CLEAR/TOGGLE of the output register, per-pin output
// enables, synchronised pin inputs and (optionally) maskable sticky rise/fall
// edge flags.
//
// Parameters:
//   GPIOWIDTH  : number of pins, 1..16
//   SYNCSTAGES : input synchroniser depth, 2..4
//
// Ports:
//   clk          : IO clock, all state on the rising edge
//   async_rst_n  : asynchronous active-low reset
//   clk_en       : global enable; low freezes every register
//   ioBus        : command/response channel (slave modport)
//   GPIO_DIn     : asynchronous pin inputs
//   GPIO_DOut    : pin output values
//   GPIO_DOutEn  : per-pin output enables
//   EdgePending  : OR of all edge flags
//
// Build option:
//   GPIO_EDGE_DETECT_EN : when defined, adds the edge flags, their masks,
//                         opcodes 7..9 and EdgePending. When undefined those
//                         opcodes are no-ops returning 0 and EdgePending is 0.
//
// Opcodes (IOOut_Data[19:16]), value in IOOut_Data[GPIOWIDTH-1:0]:
//   0 WRITE  1 SET  2 CLEAR  3 TOGGLE  4 WRITE_OE  5 READ_IN  6 READ_OUT
//   7 READ_EDGES  8 SET_RISE_MASK  9 SET_FALL_MASK  10..15 no-op
// ----------------------------------------------------------------------------
module gpio_bank_controller #(
  parameter int GPIOWIDTH  = 16,
  parameter int SYNCSTAGES = 2
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  clk_en,
  gpio_bank_controller_if.slave ioBus,
  input  logic [GPIOWIDTH-1:0]  GPIO_DIn,
  output logic [GPIOWIDTH-1:0]  GPIO_DOut,
  output logic [GPIOWIDTH-1:0]  GPIO_DOutEn,
  output logic                  EdgePending
);

  localparam logic [3:0] OP_WRITE      = 4'd0;
  localparam logic [3:0] OP_SET        = 4'd1;
  localparam logic [3:0] OP_CLEAR      = 4'd2;
  localparam logic [3:0] OP_TOGGLE     = 4'd3;
  localparam logic [3:0] OP_WRITE_OE   = 4'd4;
  localparam logic [3:0] OP_READ_IN    = 4'd5;
  localparam logic [3:0] OP_READ_OUT   = 4'd6;
`ifdef GPIO_EDGE_DETECT_EN
  localparam logic [3:0] OP_READ_EDGES = 4'd7;
  localparam logic [3:0] OP_RISE_MASK  = 4'd8;
  localparam logic [3:0] OP_FALL_MASK  = 4'd9;
`endif

  typedef enum logic {
    IDLE    = 1'b0,
    RESPOND = 1'b1
  } stateT;

  stateT stateReg;
  stateT stateNext;

  logic                 accept;
  logic [3:0]           opcode;
  logic [GPIOWIDTH-1:0] value;

  logic [GPIOWIDTH-1:0] doutReg;
  logic [GPIOWIDTH-1:0] doutNext;
  logic [GPIOWIDTH-1:0] oeReg;
  logic [GPIOWIDTH-1:0] oeNext;
  logic [15:0]          respDataReg;
  logic [15:0]          respValue;
  logic [3:0]           respTagReg;

  // Synchroniser: stage 0 samples the pins, the top stage is the clean input.
  logic [SYNCSTAGES-1:0][GPIOWIDTH-1:0] syncReg;
  logic [GPIOWIDTH-1:0]                 syncIn;

  assign opcode = ioBus.IOOut_Data[19:16];
  assign value  = ioBus.IOOut_Data[GPIOWIDTH-1:0];
  assign syncIn = syncReg[SYNCSTAGES-1];

  // --------------------------------------------------------------------------
  // Handshake FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // ACK is gated by the reset input itself so that it reads 0 for the whole
  // time reset is asserted, not just from the first clock edge onward.
  always_comb begin
    stateNext       = stateReg;
    accept          = 1'b0;
    ioBus.IOOut_ACK = 1'b0;
    case (stateReg)
      IDLE: begin
        ioBus.IOOut_ACK = clk_en && async_rst_n;
        accept          = ioBus.IOOut_REQ && clk_en && async_rst_n;
        if (accept && ioBus.IOOut_ResponseRequested) begin
          stateNext = RESPOND;
        end
      end
      RESPOND: begin
        if (ioBus.IOIn_ACK && clk_en) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Edge detection
  // --------------------------------------------------------------------------
`ifdef GPIO_EDGE_DETECT_EN
  logic [GPIOWIDTH-1:0] prevReg;
  logic [GPIOWIDTH-1:0] riseMaskReg;
  logic [GPIOWIDTH-1:0] riseMaskNext;
  logic [GPIOWIDTH-1:0] fallMaskReg;
  logic [GPIOWIDTH-1:0] fallMaskNext;
  logic [GPIOWIDTH-1:0] riseReg;
  logic [GPIOWIDTH-1:0] fallReg;
  logic [GPIOWIDTH-1:0] riseSet;
  logic [GPIOWIDTH-1:0] fallSet;
  logic [15:0]          edgeWord;
  logic                 clearFlags;

  // Detection uses the masks as they were before this edge, so a mask write
  // takes effect from the following edge.
  assign riseSet = syncIn & ~prevReg & riseMaskReg;
  assign fallSet = ~syncIn & prevReg & fallMaskReg;

  assign EdgePending = |{riseReg, fallReg};

  // Narrow banks report rise and fall separately ({fall, rise} in bytes);
  // wide banks do not fit both, so each pin reports rise|fall.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : gEdgeWord
      if (GPIOWIDTH <= 8) begin : gNarrow
        if (gi < GPIOWIDTH) begin : gRise
          assign edgeWord[gi] = riseReg[gi];
        end else if ((gi >= 8) && (gi < 8 + GPIOWIDTH)) begin : gFall
          assign edgeWord[gi] = fallReg[gi-8];
        end else begin : gZero
          assign edgeWord[gi] = 1'b0;
        end
      end else begin : gWide
        if (gi < GPIOWIDTH) begin : gPin
          assign edgeWord[gi] = riseReg[gi] | fallReg[gi];
        end else begin : gZero
          assign edgeWord[gi] = 1'b0;
        end
      end
    end
  endgenerate

  // A clear from READ_EDGES loses to a set on the same edge, so the edge that
  // arrives together with the read survives for the next read.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      prevReg     <= '0;
      riseMaskReg <= '0;
      fallMaskReg <= '0;
      riseReg     <= '0;
      fallReg     <= '0;
    end else if (clk_en) begin
      prevReg     <= syncIn;
      riseMaskReg <= riseMaskNext;
      fallMaskReg <= fallMaskNext;
      riseReg     <= (clearFlags ? '0 : riseReg) | riseSet;
      fallReg     <= (clearFlags ? '0 : fallReg) | fallSet;
    end
  end
`else
  assign EdgePending = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Command decode: next register values and the response word
  // --------------------------------------------------------------------------
  always_comb begin
    doutNext     = doutReg;
    oeNext       = oeReg;
    respValue    = '0;
`ifdef GPIO_EDGE_DETECT_EN
    riseMaskNext = riseMaskReg;
    fallMaskNext = fallMaskReg;
    clearFlags   = 1'b0;
`endif
    if (accept) begin
      case (opcode)
        OP_WRITE: begin
          doutNext  = value;
          respValue = 16'(value);
        end
        OP_SET: begin
          doutNext  = doutReg | value;
          respValue = 16'(doutReg | value);
        end
        OP_CLEAR: begin
          doutNext  = doutReg & ~value;
          respValue = 16'(doutReg & ~value);
        end
        OP_TOGGLE: begin
          doutNext  = doutReg ^ value;
          respValue = 16'(doutReg ^ value);
        end
        OP_WRITE_OE: begin
          oeNext    = value;
          respValue = 16'(value);
        end
        OP_READ_IN: begin
          respValue = 16'(syncIn);
        end
        OP_READ_OUT: begin
          respValue = 16'(doutReg);
        end
`ifdef GPIO_EDGE_DETECT_EN
        OP_READ_EDGES: begin
          respValue  = edgeWord;
          clearFlags = 1'b1;
        end
        OP_RISE_MASK: begin
          riseMaskNext = value;
          respValue    = 16'(value);
        end
        OP_FALL_MASK: begin
          fallMaskNext = value;
          respValue    = 16'(value);
        end
`endif
        default: begin
          respValue = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      syncReg     <= '0;
      doutReg     <= '0;
      oeReg       <= '0;
      respDataReg <= '0;
      respTagReg  <= '0;
    end else if (clk_en) begin
      syncReg <= {syncReg[SYNCSTAGES-2:0], GPIO_DIn};
      doutReg <= doutNext;
      oeReg   <= oeNext;
      // The response is latched once at acceptance and held through RESPOND.
      if (accept && ioBus.IOOut_ResponseRequested) begin
        respDataReg <= respValue;
        respTagReg  <= ioBus.IOOut_DestReg;
      end
    end
  end

  assign GPIO_DOut   = doutReg;
  assign GPIO_DOutEn = oeReg;

  assign ioBus.IOIn_REQ             = (stateReg == RESPOND);
  assign ioBus.IOIn_RegResponseFlag = (stateReg == RESPOND);
  assign ioBus.IOIn_MemResponseFlag = 1'b0;
  assign ioBus.IOIn_DestReg         = respTagReg;
  assign ioBus.IOIn_Data            = respDataReg;

endmodule
